// File: rtl/cellnet_source_pkg.sv
// Shared definitions for the cellnet source: link widths and source FSM encodings.
package cellnet_source_pkg;

   localparam int unsigned ADDRESS_SIZE = 8;
   localparam int unsigned DATA_SIZE    = 8;

   typedef enum logic [2:0] {
      SRC_IDLE = 3'd0,
      SRC_REQ  = 3'd1,
      SRC_REL  = 3'd2,
      SRC_GAP  = 3'd3,
      SRC_DONE = 3'd4,
      SRC_ERR  = 3'd5
   } src_state_t;

endpackage

// File: rtl/cellnet_ack_timer.sv
// Ack watchdog for cellnet link masters: down-counter reloaded on clear,
// expired asserts on the TIMEOUT-th consecutive run cycle. TIMEOUT=0 disables it.
module cellnet_ack_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_run,
   output logic o_expired
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] LOAD = (TIMEOUT > 1) ? TW'(TIMEOUT - 1) : '0;

   logic [TW-1:0] cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         cnt <= '0;
      else if (i_clear)
         cnt <= LOAD;
      else if (i_run && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign o_expired = (TIMEOUT != 0) && i_run && (cnt == '0);

endmodule

// File: rtl/cellnet_source.sv
// Incrementing-data source for the cellnet 4-phase req/ack link, with transfer
// count, inter-transfer gap and ack watchdog.
//
// state    | meaning
// SRC_IDLE | waiting for i_en
// SRC_REQ  | o_req high, waiting for ack rise
// SRC_REL  | o_req low, waiting for ack fall
// SRC_GAP  | idle gap between transfers
// SRC_DONE | COUNT transfers done, sticky until reset
// SRC_ERR  | ack watchdog expired, sticky until reset
module cellnet_source
   import cellnet_source_pkg::*;
#(
   parameter int unsigned DST_ADDR = 1,
   parameter int unsigned ASZ      = ADDRESS_SIZE,
   parameter int unsigned DSZ      = DATA_SIZE,
   parameter int unsigned COUNT    = 0,
   parameter int unsigned GAP      = 0,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_en,
   input  logic           i_ack,
   output logic [ASZ-1:0] o_addr,
   output logic [DSZ-1:0] o_dat,
   output logic           o_req,
   output logic           o_busy,
   output logic           o_done,
   output logic           o_err,
   output logic [31:0]    o_cnt
);

   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GLOAD = (GAP > 1) ? GW'(GAP - 1) : '0;

   src_state_t     state_q, state_d;
   logic [DSZ-1:0] dat_q;
   logic [31:0]    cnt_q;
   logic [GW-1:0]  gap_q;
   logic           dat_inc, cnt_inc, gap_load;
   logic           wd_clear, wd_run, wd_expired;

   always_comb begin
      state_d  = state_q;
      dat_inc  = 1'b0;
      cnt_inc  = 1'b0;
      gap_load = 1'b0;
      case (state_q)
         SRC_IDLE: begin
            if (i_en) begin
               state_d = SRC_REQ;
               dat_inc = 1'b1;
            end
         end
         SRC_REQ: begin
            // ack is checked before the watchdog so a same-edge ack wins
            if (i_ack)
               state_d = SRC_REL;
            else if (wd_expired)
               state_d = SRC_ERR;
         end
         SRC_REL: begin
            if (!i_ack) begin
               cnt_inc = 1'b1;
               if (COUNT != 0 && (cnt_q + 32'd1) == COUNT)
                  state_d = SRC_DONE;
               else if (GAP != 0) begin
                  state_d  = SRC_GAP;
                  gap_load = 1'b1;
               end else if (i_en) begin
                  state_d = SRC_REQ;
                  dat_inc = 1'b1;
               end else
                  state_d = SRC_IDLE;
            end else if (wd_expired)
               state_d = SRC_ERR;
         end
         SRC_GAP: begin
            if (gap_q == '0) begin
               if (i_en) begin
                  state_d = SRC_REQ;
                  dat_inc = 1'b1;
               end else
                  state_d = SRC_IDLE;
            end
         end
         SRC_DONE: state_d = SRC_DONE;
         SRC_ERR:  state_d = SRC_ERR;
         default:  state_d = SRC_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= SRC_IDLE;
         dat_q   <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         if (dat_inc)
            dat_q <= dat_q + 1'b1;
         if (cnt_inc)
            cnt_q <= cnt_q + 32'd1;
         if (gap_load)
            gap_q <= GLOAD;
         else if (state_q == SRC_GAP && gap_q != '0)
            gap_q <= gap_q - 1'b1;
      end
   end

   assign wd_run   = (state_q == SRC_REQ) || (state_q == SRC_REL);
   assign wd_clear = (state_d != state_q) && ((state_d == SRC_REQ) || (state_d == SRC_REL));

   cellnet_ack_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_ack_timer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (wd_clear),
      .i_run     (wd_run),
      .o_expired (wd_expired)
   );

   assign o_addr = ASZ'(DST_ADDR);
   assign o_dat  = dat_q;
   assign o_cnt  = cnt_q;
   assign o_req  = (state_q == SRC_REQ);
   assign o_busy = (state_q == SRC_REQ) || (state_q == SRC_REL) || (state_q == SRC_GAP);
   assign o_done = (state_q == SRC_DONE);
   assign o_err  = (state_q == SRC_ERR);

endmodule

// File: tb/tb_cellnet_source.sv
// Directed bench for cellnet_source against a behavioural registered-ack sink.
module tb_cellnet_source;

   logic clk = 1'b0;
   logic rst;
   logic en_a, en_b, en_c, en_d;
   logic ack_a, ack_b, ack_d;
   logic ack_c;

   logic [7:0]  addr_a, addr_b, addr_c, addr_d;
   logic [7:0]  dat_a, dat_c, dat_d;
   logic [3:0]  dat_b;
   logic        req_a, req_b, req_c, req_d;
   logic        busy_a, busy_b, busy_c, busy_d;
   logic        done_a, done_b, done_c, done_d;
   logic        err_a, err_b, err_c, err_d;
   logic [31:0] cnt_a, cnt_b, cnt_c, cnt_d;

   int n_cmp = 0;
   int n_mis = 0;

   logic [7:0] words_a[$];
   logic [3:0] words_b[$];
   int         rise_b[$];
   int         cyc = 0;
   logic       req_b_prev = 1'b0;

   always #20 clk = ~clk;

   cellnet_source #(.DST_ADDR(1), .COUNT(5), .GAP(0), .TIMEOUT(255)) u_a (
      .i_clk(clk), .i_rst(rst), .i_en(en_a), .i_ack(ack_a), .o_addr(addr_a), .o_dat(dat_a),
      .o_req(req_a), .o_busy(busy_a), .o_done(done_a), .o_err(err_a), .o_cnt(cnt_a));

   cellnet_source #(.DST_ADDR(1), .DSZ(4), .COUNT(0), .GAP(3), .TIMEOUT(255)) u_b (
      .i_clk(clk), .i_rst(rst), .i_en(en_b), .i_ack(ack_b), .o_addr(addr_b), .o_dat(dat_b),
      .o_req(req_b), .o_busy(busy_b), .o_done(done_b), .o_err(err_b), .o_cnt(cnt_b));

   cellnet_source #(.DST_ADDR(1), .COUNT(0), .GAP(0), .TIMEOUT(10)) u_c (
      .i_clk(clk), .i_rst(rst), .i_en(en_c), .i_ack(ack_c), .o_addr(addr_c), .o_dat(dat_c),
      .o_req(req_c), .o_busy(busy_c), .o_done(done_c), .o_err(err_c), .o_cnt(cnt_c));

   cellnet_source #(.DST_ADDR(1), .COUNT(3), .GAP(0), .TIMEOUT(2)) u_d (
      .i_clk(clk), .i_rst(rst), .i_en(en_d), .i_ack(ack_d), .o_addr(addr_d), .o_dat(dat_d),
      .o_req(req_d), .o_busy(busy_d), .o_done(done_d), .o_err(err_d), .o_cnt(cnt_d));

   // sink: registered ack follows req when addressed to it; word captured on ack rise
   always @(posedge clk) begin
      if (rst) begin
         ack_a <= 1'b0;
         ack_b <= 1'b0;
         ack_d <= 1'b0;
      end else begin
         ack_a <= req_a && (addr_a == 8'd1);
         ack_b <= req_b && (addr_b == 8'd1);
         ack_d <= req_d && (addr_d == 8'd1);
         if (req_a && !ack_a && addr_a == 8'd1) words_a.push_back(dat_a);
         if (req_b && !ack_b && addr_b == 8'd1) words_b.push_back(dat_b);
      end
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (req_b && !req_b_prev) rise_b.push_back(cyc);
      req_b_prev = req_b;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      ack_c = 1'b0;
      rst = 1'b1;
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req",  {31'd0, req_a},  32'd0);
      check("rst_busy", {31'd0, busy_a}, 32'd0);
      check("rst_done", {31'd0, done_a}, 32'd0);
      check("rst_err",  {31'd0, err_a},  32'd0);
      check("rst_cnt",  cnt_a,           32'd0);
      check("rst_dat",  {24'd0, dat_a},  32'd0);
      check("rst_addr", {addr_a, addr_b, addr_c, addr_d}, 32'h01010101);
      rst = 1'b0;
      @(negedge clk);

      // 1: COUNT=5 back-to-back
      en_a = 1'b1;
      @(negedge clk);
      check("t1_req_latency", {31'd0, req_a}, 32'd1);
      check("t1_first_dat", {24'd0, dat_a}, 32'd1);
      for (int i = 0; i < 100 && !done_a; i++) @(negedge clk);
      check("t1_done", {31'd0, done_a}, 32'd1);
      check("t1_cnt", cnt_a, 32'd5);
      check("t1_dat", {24'd0, dat_a}, 32'd5);
      check("t1_req_busy_err", {29'd0, req_a, busy_a, err_a}, 32'd0);
      repeat (5) @(negedge clk);
      check("t1_done_sticky", {31'd0, done_a}, 32'd1);
      check("t1_cnt_hold", cnt_a, 32'd5);
      check("t1_nwords", 32'(words_a.size()), 32'd5);
      for (int k = 0; k < 5; k++)
         if (words_a.size() > k) check("t1_word", {24'd0, words_a[k]}, 32'(k + 1));

      // 2/4: GAP=3, 4-bit data wrap over 20 transfers
      en_b = 1'b1;
      for (int i = 0; i < 400 && cnt_b != 32'd20; i++) @(negedge clk);
      en_b = 1'b0;
      repeat (8) @(negedge clk);
      check("t2_cnt", cnt_b, 32'd20);
      check("t2_dat", {28'd0, dat_b}, 32'd4);
      check("t2_idle", {28'd0, req_b, busy_b, done_b, err_b}, 32'd0);
      check("t2_nwords", 32'(words_b.size()), 32'd20);
      for (int k = 0; k < 20; k++)
         if (words_b.size() > k) check("t4_wrap_word", {28'd0, words_b[k]}, 32'((k + 1) % 16));
      check("t2_nrise", 32'(rise_b.size()), 32'd20);
      if (rise_b.size() >= 20) begin
         check("t2_period_early", 32'(rise_b[2] - rise_b[1]), 32'd7);
         check("t2_period_wrap", 32'(rise_b[16] - rise_b[15]), 32'd7);
         check("t2_period_last", 32'(rise_b[19] - rise_b[18]), 32'd7);
      end

      // 3: no ack, TIMEOUT=10
      en_c = 1'b1;
      n = 0;
      for (int i = 0; i < 50 && !err_c; i++) begin
         @(negedge clk);
         if (req_c) n++;
      end
      check("t3_req_cycles", 32'(n), 32'd10);
      check("t3_err", {31'd0, err_c}, 32'd1);
      check("t3_req_busy_done", {29'd0, req_c, busy_c, done_c}, 32'd0);
      check("t3_cnt", cnt_c, 32'd0);
      check("t3_dat", {24'd0, dat_c}, 32'd1);
      repeat (3) @(negedge clk);
      check("t3_err_sticky", {31'd0, err_c}, 32'd1);

      // ack landing exactly at the watchdog limit must win (TIMEOUT=2)
      en_d = 1'b1;
      for (int i = 0; i < 100 && !done_d && !err_d; i++) @(negedge clk);
      check("td_done", {31'd0, done_d}, 32'd1);
      check("td_err", {31'd0, err_d}, 32'd0);
      check("td_cnt", cnt_d, 32'd3);
      check("td_dat_busy", {23'd0, dat_d, busy_d}, {23'd0, 8'd3, 1'b0});

      // 5: drop i_en mid-REQ
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("t5_rst_clears_done", {30'd0, done_a, err_c}, 32'd0);
      rst = 1'b0;
      en_a = 1'b1;
      @(negedge clk);
      check("t5_in_req", {31'd0, req_a}, 32'd1);
      en_a = 1'b0;
      for (int i = 0; i < 20 && cnt_a != 32'd1; i++) @(negedge clk);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (req_a) n++;
      end
      check("t5_no_more_req", 32'(n), 32'd0);
      check("t5_cnt", cnt_a, 32'd1);
      check("t5_dat", {24'd0, dat_a}, 32'd1);
      check("t5_idle", {29'd0, busy_a, done_a, err_a}, 32'd0);

      // 6: reset while o_req is high
      en_a = 1'b1;
      for (int i = 0; i < 10 && !req_a; i++) @(negedge clk);
      check("t6_req_before", {24'd0, dat_a}, 32'd2);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_flags", {28'd0, req_a, busy_a, done_a, err_a}, 32'd0);
      check("t6_rst_dat", {24'd0, dat_a}, 32'd0);
      check("t6_rst_cnt", cnt_a, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("t6_restart_req", {31'd0, req_a}, 32'd1);
      check("t6_restart_dat", {24'd0, dat_a}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
